// File: rtl/lspc_irq_timer.sv
// lspc_irq_timer: LSPC 32-bit raster timer and IRQ1/IRQ2/IRQ3 request sequencer.
// Optional PAL top/bottom freeze enabled by defining LSPC_TIMER_PAL_STOP_EN.
module lspc_irq_timer #(
  parameter int CNT_W = 32
`ifdef LSPC_TIMER_PAL_STOP_EN
  , parameter int PAL_STOP_LINES = 16
`endif
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLK_EN_6M,
  input  logic             VBL_START,
  input  logic [8:0]       RASTERC,
  input  logic             VMODE,
  input  logic             WR_EN,
  input  logic [2:0]       WR_ADDR,
  input  logic [15:0]      WR_DATA,
  output logic [CNT_W-1:0] TIMER_VAL,
  output logic             IRQ_VBL,
  output logic             IRQ_TIMER,
  output logic             IRQ_RESET
);
  logic [CNT_W-1:0] reload, cnt, cnt_nxt;
  logic [3:0] mode;
  logic irq_vbl, irq_timer, irq_reset;
  logic wr_reload, vbl_reload, tick, underflow, ack, frozen;
  assign ack        = WR_EN && WR_ADDR == 3'd6;
  assign wr_reload  = WR_EN && WR_ADDR == 3'd5 && mode[1];
  assign vbl_reload = VBL_START && mode[2];
  assign tick       = CLK_EN_6M && !frozen && !wr_reload && !vbl_reload;
  assign underflow  = tick && cnt == '0;
`ifdef LSPC_TIMER_PAL_STOP_EN
  logic stop;
  assign frozen = stop && VMODE && (int'(RASTERC) < 'h100 + PAL_STOP_LINES ||
                                    int'(RASTERC) >= 'h1F8 - PAL_STOP_LINES + 8);
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) stop <= 1'b0;
    else if (WR_EN && WR_ADDR == 3'd7) stop <= WR_DATA[0];
`else
  logic unused_raster;
  assign unused_raster = ^{VMODE, RASTERC};
  assign frozen = 1'b0;
`endif
  // Write reload beats VBL reload beats the pixel tick.
  assign cnt_nxt = wr_reload  ? {reload[CNT_W-1:16], WR_DATA} :
                   vbl_reload ? reload :
                   !tick      ? cnt :
                   !underflow ? cnt - 1'b1 :
                   mode[3]    ? reload : {CNT_W{1'b1}};
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      reload    <= '0;
      cnt       <= '0;
      mode      <= '0;
      irq_vbl   <= 1'b0;
      irq_timer <= 1'b0;
      irq_reset <= 1'b1;
    end else begin
      if (WR_EN && WR_ADDR == 3'd0) mode <= WR_DATA[7:4];
      if (WR_EN && WR_ADDR == 3'd4) reload[CNT_W-1:16] <= WR_DATA;
      if (WR_EN && WR_ADDR == 3'd5) reload[15:0] <= WR_DATA;
      cnt       <= cnt_nxt;
      irq_vbl   <= VBL_START || (irq_vbl && !(ack && WR_DATA[2]));
      irq_timer <= (underflow && mode[0]) || (irq_timer && !(ack && WR_DATA[1]));
      irq_reset <= irq_reset && !(ack && WR_DATA[0]);
    end
  assign TIMER_VAL = cnt;
  assign IRQ_VBL   = irq_vbl;
  assign IRQ_TIMER = irq_timer;
  assign IRQ_RESET = irq_reset;
endmodule
